// File: rtl/ushift_register.sv
// Universal shift register: parallel load, sync clear, left/right serial shift.
// Define USHIFT_FRAME_EN to build the frame counter, o_count and o_frame_done.
module ushift_register #(
  parameter int BITS  = 32,
  parameter int CNT_W = $clog2(BITS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_sclr,
  input  logic             i_load,
  input  logic [BITS-1:0]  i_pdat,
  input  logic             i_en,
  input  logic             i_dir,
  input  logic             i_dat,
  output logic [BITS-1:0]  o_data,
  output logic             o_sout,
  output logic             o_frame_done,
  output logic [CNT_W-1:0] o_count
);

  logic [BITS-1:0] shift_q;
  logic [BITS-1:0] shift_d;

  always_comb begin
    shift_d = shift_q;
    if (i_sclr)
      shift_d = '0;
    else if (i_load)
      shift_d = i_pdat;
    else if (i_en)
      shift_d = i_dir ? {i_dat, shift_q[BITS-1:1]} : {shift_q[BITS-2:0], i_dat};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      shift_q <= '0;
    else
      shift_q <= shift_d;
  end

  assign o_data = shift_q;
  assign o_sout = i_dir ? shift_q[0] : shift_q[BITS-1];

`ifdef USHIFT_FRAME_EN
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BITS - 1);

  logic [CNT_W-1:0] count_q;
  logic             done_q;

  // The shift that would take the count to BITS wraps it to zero and fires the pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      done_q  <= 1'b0;
    end else if (i_sclr || i_load) begin
      count_q <= '0;
      done_q  <= 1'b0;
    end else if (i_en) begin
      if (count_q == LAST) begin
        count_q <= '0;
        done_q  <= 1'b1;
      end else begin
        count_q <= count_q + 1'b1;
        done_q  <= 1'b0;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign o_count      = count_q;
  assign o_frame_done = done_q;
`else
  assign o_count      = '0;
  assign o_frame_done = 1'b0;
`endif

endmodule

// File: tb/tb_ushift_register.sv
// Directed bench for ushift_register: an 8-bit and a 4-bit instance share controls.
// Frame expectations follow USHIFT_FRAME_EN so both builds are checked.
module tb_ushift_register;

`ifdef USHIFT_FRAME_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       sclr, load, en, dir, dat;
  logic [7:0] pdat;

  logic [7:0] data8;
  logic       sout8, done8;
  logic [3:0] count8;
  logic [3:0] data4;
  logic       sout4, done4;
  logic [2:0] count4;

  int vectors = 0;
  int miscompares = 0;

  ushift_register #(.BITS(8)) u8 (
    .clk(clk), .reset(reset), .i_sclr(sclr), .i_load(load), .i_pdat(pdat),
    .i_en(en), .i_dir(dir), .i_dat(dat), .o_data(data8), .o_sout(sout8),
    .o_frame_done(done8), .o_count(count8)
  );

  ushift_register #(.BITS(4)) u4 (
    .clk(clk), .reset(reset), .i_sclr(sclr), .i_load(load), .i_pdat(pdat[3:0]),
    .i_en(en), .i_dir(dir), .i_dat(dat), .o_data(data4), .o_sout(sout4),
    .o_frame_done(done4), .o_count(count4)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic s, input logic l, input logic [7:0] p,
                               input logic e, input logic d, input logic b);
    sclr = s; load = l; pdat = p; en = e; dir = d; dat = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Frame outputs read as zero when the counter is not built.
  function automatic logic [31:0] fx(input logic [31:0] v);
    return FE ? v : 32'd0;
  endfunction

  logic [7:0] sout_seq;

  initial begin
    reset = 1'b1;
    applyStimulus(0, 0, 8'h00, 0, 0, 0);
    #2;
    checkOutput("reset_data", data8, 8'h00);
    checkOutput("reset_count", count8, 0);
    checkOutput("reset_done", done8, 0);
    checkOutput("reset_sout", sout8, 0);
    reset = 1'b0;

    // Load 0xA5 then eight left shifts of 1
    applyStimulus(0, 1, 8'hA5, 0, 0, 0);
    tick();
    checkOutput("load_a5", data8, 8'hA5);
    checkOutput("load_count", count8, 0);
    applyStimulus(0, 0, 8'h00, 0, 1, 1);
    checkOutput("sout_right_lsb", sout8, 1);
    sout_seq = 8'hA5;
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(0, 0, 8'h00, 1, 0, 1);
      checkOutput($sformatf("sout_seq%0d", k), sout8, sout_seq[8-k]);
      tick();
      checkOutput($sformatf("shl_count%0d", k), count8, fx(k % 8));
      checkOutput($sformatf("shl_done%0d", k), done8, fx(k == 8));
    end
    checkOutput("shl_final", data8, 8'hFF);
    applyStimulus(0, 0, 8'h00, 0, 0, 0);
    tick();
    checkOutput("done_drops", done8, 0);
    checkOutput("hold_data", data8, 8'hFF);

    // Clear, then three right shifts of 1
    applyStimulus(1, 0, 8'h00, 0, 0, 0);
    tick();
    checkOutput("sclr_data", data8, 8'h00);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 8'h00, 1, 1, 1);
      tick();
    end
    checkOutput("shr3_data", data8, 8'hE0);
    checkOutput("shr3_count", count8, fx(3));
    checkOutput("shr3_done", done8, 0);

    // 4-bit back-to-back frames
    applyStimulus(1, 0, 8'h00, 0, 0, 0);
    tick();
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(0, 0, 8'h00, 1, 0, 0);
      tick();
      checkOutput($sformatf("b4_count%0d", k), count4, fx(k % 4));
      checkOutput($sformatf("b4_done%0d", k), done4, fx((k % 4) == 0));
    end

    // Priority: clear beats load and shift, load beats shift
    applyStimulus(1, 1, 8'h5A, 1, 0, 1);
    tick();
    checkOutput("prio_sclr_data", data8, 8'h00);
    checkOutput("prio_sclr_count", count8, 0);
    applyStimulus(0, 1, 8'h3C, 1, 0, 1);
    tick();
    checkOutput("prio_load_data", data8, 8'h3C);
    checkOutput("prio_load_count", count8, 0);

    // Load on the would-be wrapping edge suppresses the pulse
    for (int k = 0; k < 7; k++) begin
      applyStimulus(0, 0, 8'h00, 1, 0, 0);
      tick();
    end
    checkOutput("pre_wrap_count", count8, fx(7));
    applyStimulus(0, 1, 8'h11, 1, 0, 0);
    tick();
    checkOutput("load_wrap_done", done8, 0);
    checkOutput("load_wrap_count", count8, 0);
    checkOutput("load_wrap_data", data8, 8'h11);

    // Asynchronous reset mid-frame
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 0, 8'h00, 1, 0, 1);
      tick();
    end
    checkOutput("mid_count5", count8, fx(5));
    applyStimulus(0, 0, 8'h00, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_data", data8, 8'h00);
    checkOutput("async_count", count8, 0);
    checkOutput("async_sout", sout8, 0);
    #1 reset = 1'b0;

    // Fresh frame needs eight shifts; direction swap keeps counting
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(0, 0, 8'h00, 1, (k > 4), 1);
      tick();
      checkOutput($sformatf("post_count%0d", k), count8, fx(k % 8));
      checkOutput($sformatf("post_done%0d", k), done8, fx(k == 8));
    end
    checkOutput("post_data", data8, 8'hF0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
